// File: rtl/data_mem_ctrl.sv
// Byte-addressed data memory for the MIPS MEM stage: sb/sh/sw, lb/lbu/lh/lhu/lw,
// valid/ready request/response, post-reset clear sweep. Optional macro: DMEM_ALIGN_CHECK_EN.
module data_mem_ctrl #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [5:0]        opcode,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rdata,
    output logic              rsp_err,
    output logic              init_busy
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W+1)'(4 * DEPTH);

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_RESP} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   cnt;
    logic [31:0]        mem [DEPTH];

    logic               accept;
    logic               op_ok, is_load, is_signed, in_range, misaligned, err;
    size_t              size;
    logic [IDX_W-1:0]   idx;
    logic [3:0]         be;
    logic [31:0]        wlane;
    logic [31:0]        rd_word, rd_byte_sh, rd_half_sh, load_val, rsp_data;
    logic               wr_en;

    // Opcode decode.
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        op_ok     = 1'b1;
        is_load   = 1'b0;
        is_signed = 1'b0;
        size      = SZ_W;
        case (opcode)
            OP_LB:   begin is_load = 1'b1; is_signed = 1'b1; size = SZ_B; end
            OP_LH:   begin is_load = 1'b1; is_signed = 1'b1; size = SZ_H; end
            OP_LW:   begin is_load = 1'b1;                   size = SZ_W; end
            OP_LBU:  begin is_load = 1'b1;                   size = SZ_B; end
            OP_LHU:  begin is_load = 1'b1;                   size = SZ_H; end
            OP_SB:   size = SZ_B;
            OP_SH:   size = SZ_H;
            OP_SW:   size = SZ_W;
            default: op_ok = 1'b0;
        endcase
    end

    assign idx      = addr[IDX_W+1:2];
    assign in_range = ({1'b0, addr} < MEM_BYTES);

`ifdef DMEM_ALIGN_CHECK_EN
    assign misaligned = ((size == SZ_H) && addr[0]) ||
                        ((size == SZ_W) && (addr[1:0] != 2'b00));
`else
    // Low address bits are simply ignored for half/word lanes below, which
    // forces alignment without a separate masking step.
    assign misaligned = 1'b0;
`endif

    assign err = !op_ok || !in_range || misaligned;

    // Byte enables and replicated store data for the selected lanes.
    always_comb begin
        be    = 4'b1111;
        wlane = wdata;
        case (size)
            SZ_B: begin
                be    = 4'b0001 << addr[1:0];
                wlane = {4{wdata[7:0]}};
            end
            SZ_H: begin
                be    = addr[1] ? 4'b1100 : 4'b0011;
                wlane = {2{wdata[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wlane = wdata;
            end
        endcase
    end

    // Load path reads the array as it stands before the accept edge, so a
    // store accepted one cycle earlier is already visible.
    assign rd_word    = mem[idx];
    assign rd_byte_sh = rd_word >> {addr[1:0], 3'b000};
    assign rd_half_sh = rd_word >> {addr[1], 4'b0000};

    always_comb begin
        load_val = rd_word;
        case (size)
            SZ_B:    load_val = is_signed ? {{24{rd_byte_sh[7]}}, rd_byte_sh[7:0]}
                                          : {24'h0, rd_byte_sh[7:0]};
            SZ_H:    load_val = is_signed ? {{16{rd_half_sh[15]}}, rd_half_sh[15:0]}
                                          : {16'h0, rd_half_sh[15:0]};
            default: load_val = rd_word;
        endcase
    end

    assign rsp_data = (is_load && !err) ? load_val : 32'h0;
    assign wr_en    = !rst && accept && !is_load && !err;

    // FSM next state and handshake outputs.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        init_busy = 1'b0;
        accept    = 1'b0;
        case (state)
            S_INIT: begin
                init_busy = 1'b1;
                if (cnt == IDX_W'(DEPTH - 1))
                    state_nxt = S_IDLE;
            end
            S_IDLE: begin
                req_ready = 1'b1;
                accept    = req_valid;
                if (req_valid)
                    state_nxt = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                req_ready = rsp_ready;
                accept    = rsp_ready && req_valid;
                if (rsp_ready && !req_valid)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_INIT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_INIT;
            cnt     <= '0;
            rdata   <= 32'h0;
            rsp_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_INIT)
                cnt <= cnt + IDX_W'(1);
            if (accept) begin
                rdata   <= rsp_data;
                rsp_err <= err;
            end
        end
    end

    // NOTE: the array has no reset branch so it maps onto RAM; contents are
    // cleared by the INIT sweep instead of by rst.
    always_ff @(posedge clk) begin
        if (!rst && state == S_INIT) begin
            mem[cnt] <= 32'h0;
        end else if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b])
                    mem[idx][8*b +: 8] <= wlane[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: vector table plus hand-written
// sequences for reset sweep, back-to-back traffic and backpressure.
module tb_data_mem_ctrl;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [5:0]  opcode = 6'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rdata;
    logic        rsp_err;
    logic        init_busy;

    data_mem_ctrl #(.DEPTH(256), .ADDR_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .opcode    (opcode),
        .addr      (addr),
        .wdata     (wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rdata     (rdata),
        .rsp_err   (rsp_err),
        .init_busy (init_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          tag;
    } exp_t;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic        err;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[$];
    int   rsp_cyc[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   tag_n  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    // Scoreboard: each consumed response pops the oldest expectation.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            exp_t e;
            rsp_cyc.push_back(cyc);
            check("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check($sformatf("rsp%0d_rdata", e.tag), rdata, e.rdata);
                check($sformatf("rsp%0d_err", e.tag), 32'(rsp_err), 32'(e.err));
            end
        end
    end

    // All tasks start and return at posedge + 1.
    task automatic wait_accept(output int waited);
        waited = 0;
        @(negedge clk);
        while (!req_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!req_ready)
            check("accept_timeout", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd);
        req_valid = 1'b1;
        opcode    = op;
        addr      = a;
        wdata     = wd;
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] erd, input logic eerr, output int waited);
        drive(op, a, wd);
        wait_accept(waited);
        exp_q.push_back('{erd, eerr, tag_n});
        tag_n++;
    endtask

    task automatic drain();
        int n = 0;
        req_valid = 1'b0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic count_sweep(input string name);
        int n = 0;
        @(negedge clk);
        while (init_busy && n < 2000) begin
            n++;
            @(negedge clk);
        end
        check(name, 32'(n), 32'd256);
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rd, input logic e);
        vecs.push_back('{op, a, wd, rd, e});
    endtask

    initial begin
        #500_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int w;
        int base;

        // Reset values, then initial sweep length.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_init_busy", 32'(init_busy), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        count_sweep("sweep0_len");
        check("idle_req_ready", 32'(req_ready), 32'd1);

        // Preload word 5, leave a load response stuck, reset mid-response.
        issue(OP_SW, 32'h14, 32'hFFFF_FFFF, 32'h0, 1'b0, w);
        issue(OP_LW, 32'h14, 32'h0, 32'hFFFF_FFFF, 1'b0, w);
        drain();
        rsp_ready = 1'b0;
        issue(OP_LW, 32'h14, 32'h0, 32'hFFFF_FFFF, 1'b0, w);
        req_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        rsp_ready = 1'b1;
        check("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_mid_rdata", rdata, 32'h0);
        check("rst_mid_init_busy", 32'(init_busy), 32'd1);
        count_sweep("sweep1_len");
        issue(OP_LW, 32'h14, 32'h0, 32'h0, 1'b0, w);
        drain();

        // Vector table: lanes, extension, ranges, opcodes, alignment.
        add(OP_SW,  32'h10, 32'hA1B2_C3D4, 32'h0,         1'b0);
        add(OP_SB,  32'h11, 32'hDEAD_BE7E, 32'h0,         1'b0);
        add(OP_LW,  32'h10, 32'h0,         32'hA1B2_7ED4, 1'b0);
        add(OP_LB,  32'h13, 32'h0,         32'hFFFF_FFA1, 1'b0);
        add(OP_LBU, 32'h13, 32'h0,         32'h0000_00A1, 1'b0);
        add(OP_LB,  32'h11, 32'h0,         32'h0000_007E, 1'b0);
        add(OP_LHU, 32'h10, 32'h0,         32'h0000_7ED4, 1'b0);
        add(OP_SH,  32'h22, 32'h1234_8001, 32'h0,         1'b0);
        add(OP_LH,  32'h22, 32'h0,         32'hFFFF_8001, 1'b0);
        add(OP_LHU, 32'h22, 32'h0,         32'h0000_8001, 1'b0);
        add(OP_LW,  32'h20, 32'h0,         32'h8001_0000, 1'b0);
        add(OP_LW,  32'h3FC, 32'h0,        32'h0,         1'b0);
        add(OP_SW,  32'h400, 32'h5555_5555, 32'h0,        1'b1);
        add(OP_LW,  32'h0,  32'h0,         32'h0,         1'b0);
        add(OP_SW,  32'h3FC, 32'h1357_2468, 32'h0,        1'b0);
        add(OP_LW,  32'h3FC, 32'h0,        32'h1357_2468, 1'b0);
        add(OP_LW,  32'h400, 32'h0,        32'h0,         1'b1);
        add(OP_LW,  32'hFFFF_FFFC, 32'h0,  32'h0,         1'b1);
        add(6'h2A,  32'h10, 32'hFFFF_FFFF, 32'h0,         1'b1);
        add(6'h22,  32'h10, 32'h0,         32'h0,         1'b1);
        add(OP_LW,  32'h10, 32'h0,         32'hA1B2_7ED4, 1'b0);
`ifdef DMEM_ALIGN_CHECK_EN
        add(OP_LW,  32'h12, 32'h0,         32'h0,         1'b1);
        add(OP_LHU, 32'h23, 32'h0,         32'h0,         1'b1);
        add(OP_SH,  32'h21, 32'h0000_BEEF, 32'h0,         1'b1);
`else
        add(OP_LW,  32'h12, 32'h0,         32'hA1B2_7ED4, 1'b0);
        add(OP_LHU, 32'h23, 32'h0,         32'h0000_8001, 1'b0);
        add(OP_SH,  32'h21, 32'h0000_BEEF, 32'h0,         1'b0);
`endif
        for (int i = 0; i < vecs.size(); i++)
            issue(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].rd, vecs[i].err, w);
        drain();
`ifdef DMEM_ALIGN_CHECK_EN
        issue(OP_LW, 32'h20, 32'h0, 32'h8001_0000, 1'b0, w);
`else
        issue(OP_LW, 32'h20, 32'h0, 32'h8001_BEEF, 1'b0, w);
`endif
        drain();

        // Back-to-back loads with rsp_ready held high.
        base = rsp_cyc.size();
        issue(OP_LW, 32'h10,  32'h0, 32'hA1B2_7ED4, 1'b0, w); check("b2b_wait0", 32'(w), 32'd0);
        issue(OP_LW, 32'h14,  32'h0, 32'h0,         1'b0, w); check("b2b_wait1", 32'(w), 32'd0);
        issue(OP_LW, 32'h18,  32'h0, 32'h0,         1'b0, w); check("b2b_wait2", 32'(w), 32'd0);
        issue(OP_LW, 32'h1C,  32'h0, 32'h0,         1'b0, w); check("b2b_wait3", 32'(w), 32'd0);
        issue(OP_LW, 32'h3FC, 32'h0, 32'h1357_2468, 1'b0, w); check("b2b_wait4", 32'(w), 32'd0);
        issue(OP_LBU, 32'h12, 32'h0, 32'h0000_00B2, 1'b0, w); check("b2b_wait5", 32'(w), 32'd0);
        issue(OP_LB, 32'h10,  32'h0, 32'hFFFF_FFD4, 1'b0, w); check("b2b_wait6", 32'(w), 32'd0);
        issue(OP_LH, 32'h12,  32'h0, 32'hFFFF_A1B2, 1'b0, w); check("b2b_wait7", 32'(w), 32'd0);
        drain();
        check("b2b_rsp_count", 32'(rsp_cyc.size() - base), 32'd8);
        if (rsp_cyc.size() - base == 8)
            check("b2b_rsp_span", 32'(rsp_cyc[base+7] - rsp_cyc[base]), 32'd7);

        // Backpressure: response held while a new request waits.
        rsp_ready = 1'b0;
        issue(OP_LW, 32'h10, 32'h0, 32'hA1B2_7ED4, 1'b0, w);
        drive(OP_LHU, 32'h22, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("bp_valid%0d", k), 32'(rsp_valid), 32'd1);
            check($sformatf("bp_rdata%0d", k), rdata, 32'hA1B2_7ED4);
            check($sformatf("bp_ready%0d", k), 32'(req_ready), 32'd0);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        wait_accept(w);
        check("bp_release_wait", 32'(w), 32'd0);
        exp_q.push_back('{32'h0000_8001, 1'b0, tag_n});
        tag_n++;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
